// File: rtl/instr_write_ctrl.sv
// HPS-to-FIFO instruction write controller with frame status/count.
// Optional build macro INSTR_WRITE_CTRL_DROP_CNT_EN enables the dropped-request counter.
module instr_write_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wrreg_in,
    input  logic [DATA_W-1:0] data_a_in,
    input  logic [DATA_W-1:0] data_b_in,
    input  logic              fifo_full_in,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_data_a,
    output logic [DATA_W-1:0] fifo_data_b,
    output logic              wrfull_out,
    input  logic              screen_in,
    input  logic              reset_pulsecounter_in,
    output logic              screen_out,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  drop_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [1:0]       state;
    logic             wrreg_p1;
    logic             wr_armed;
    logic             pcnt_p1;
    logic             wr_req;
    logic             pcnt_clr;
    logic             drop_evt;
    logic [CNT_W-1:0] frame_base;

    // A request only counts once wrreg_in has been seen low, so a level held through reset is ignored.
    assign wr_req     = wrreg_in & ~wrreg_p1 & wr_armed;
    assign pcnt_clr   = reset_pulsecounter_in & ~pcnt_p1;
    assign drop_evt   = (state == IDLE) & wr_req & fifo_full_in;
    assign frame_base = pcnt_clr ? '0 : frame_count;

    // Stage p1: edge registers, write FSM and captured operands
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            fifo_wr_en  <= 1'b0;
            fifo_data_a <= '0;
            fifo_data_b <= '0;
            wrfull_out  <= 1'b0;
            wrreg_p1    <= 1'b0;
            wr_armed    <= ~wrreg_in;
            pcnt_p1     <= 1'b0;
        end else begin
            wrreg_p1   <= wrreg_in;
            pcnt_p1    <= reset_pulsecounter_in;
            wrfull_out <= fifo_full_in;
            fifo_wr_en <= 1'b0;
            if (!wrreg_in) begin
                wr_armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        if (!fifo_full_in) begin
                            fifo_data_a <= data_a_in;
                            fifo_data_b <= data_b_in;
                            state       <= WRITE;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                WRITE: begin
                    // Full is not re-checked here; overflow protection lives downstream.
                    fifo_wr_en <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (!wrreg_in) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p1: frame status; a same-cycle clear is applied before the new frame is counted
    always_ff @(posedge clock) begin
        if (reset) begin
            screen_out  <= 1'b0;
            frame_count <= '0;
        end else if (screen_in) begin
            screen_out  <= 1'b1;
            frame_count <= sat_inc(frame_base);
        end else if (pcnt_clr) begin
            screen_out  <= 1'b0;
            frame_count <= '0;
        end
    end

`ifdef INSTR_WRITE_CTRL_DROP_CNT_EN
    logic [CNT_W-1:0] drop_p1;

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_p1 <= '0;
        end else if (drop_evt) begin
            drop_p1 <= sat_inc(drop_p1);
        end
    end

    assign drop_count = drop_p1;
`else
    logic unused_drop;
    assign unused_drop = drop_evt;
    assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_instr_write_ctrl.sv
// Bench for instr_write_ctrl: directed vector table, corner sequences and a
// randomized run checked against an event-level reference model.
module tb_instr_write_ctrl;

    localparam int DW     = 32;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;
`ifdef INSTR_WRITE_CTRL_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          wrreg_in;
    logic [DW-1:0] data_a_in;
    logic [DW-1:0] data_b_in;
    logic          fifo_full_in;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_data_a;
    logic [DW-1:0] fifo_data_b;
    logic          wrfull_out;
    logic          screen_in;
    logic          reset_pulsecounter_in;
    logic          screen_out;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] drop_count;

    instr_write_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .wrreg_in              (wrreg_in),
        .data_a_in             (data_a_in),
        .data_b_in             (data_b_in),
        .fifo_full_in          (fifo_full_in),
        .fifo_wr_en            (fifo_wr_en),
        .fifo_data_a           (fifo_data_a),
        .fifo_data_b           (fifo_data_b),
        .wrfull_out            (wrfull_out),
        .screen_in             (screen_in),
        .reset_pulsecounter_in (reset_pulsecounter_in),
        .screen_out            (screen_out),
        .frame_count           (frame_count),
        .drop_count            (drop_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks;
    int errors;
    int wr_pulses;

    // Reference model: a request is honoured when the block is receptive; after a
    // write it is deaf until wrreg_in is seen low at least two edges later (one
    // edge later after a drop). Writes appear one edge after the capture edge.
    int          n;
    logic        m_prev_wr, m_prev_rpc, m_armed, m_receptive;
    int          m_block_until, m_pending_at;
    logic        m_wr_en, m_full, m_so;
    logic [31:0] m_a, m_b;
    int          m_fc, m_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model(input logic r, input logic w, input logic [31:0] a, input logic [31:0] b,
                         input logic f, input logic s, input logic p);
        logic rise, clr;
        if (r) begin
            m_wr_en = 0; m_a = 0; m_b = 0; m_full = 0; m_so = 0; m_fc = 0; m_drop = 0;
            m_prev_wr = 0; m_prev_rpc = 0; m_armed = !w; m_receptive = 1;
            m_pending_at = -1; m_block_until = 0;
        end else begin
            m_wr_en = (m_pending_at == n);
            m_full  = f;
            rise = w && !m_prev_wr && m_armed;
            if (m_receptive && rise) begin
                if (!f) begin
                    m_a = a; m_b = b;
                    m_pending_at  = n + 1;
                    m_block_until = n + 2;
                end else begin
                    if (m_drop < CNTMAX) m_drop++;
                    m_block_until = n + 1;
                end
                m_receptive = 0;
            end else if (!m_receptive && n >= m_block_until && !w) begin
                m_receptive = 1;
            end
            if (!w) m_armed = 1;
            m_prev_wr = w;
            clr = p && !m_prev_rpc;
            if (clr) begin m_fc = 0; m_so = 0; end
            if (s) begin m_so = 1; if (m_fc < CNTMAX) m_fc++; end
            m_prev_rpc = p;
        end
        n++;
    endtask

    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] b,
                        input logic f, input logic s, input logic p);
        @(negedge clock);
        reset = r; wrreg_in = w; data_a_in = a; data_b_in = b;
        fifo_full_in = f; screen_in = s; reset_pulsecounter_in = p;
        @(posedge clock);
        model(r, w, a, b, f, s, p);
        #1;
        chk("model_wr_en",   32'(fifo_wr_en),  32'(m_wr_en));
        chk("model_data_a",  fifo_data_a,      m_a);
        chk("model_data_b",  fifo_data_b,      m_b);
        chk("model_wrfull",  32'(wrfull_out),  32'(m_full));
        chk("model_screen",  32'(screen_out),  32'(m_so));
        chk("model_frames",  32'(frame_count), 32'(m_fc));
        chk("model_drops",   32'(drop_count),  DROP_EN ? 32'(m_drop) : 32'd0);
        if (fifo_wr_en === 1'b1) wr_pulses++;
    endtask

    task automatic drv(input logic w, input logic f, input logic s, input logic p);
        step(1'b0, w, $urandom, $urandom, f, s, p);
    endtask

    task automatic do_reset(input logic w);
        step(1'b1, w, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        rst, wr;
        logic [31:0] a, b;
        logic        full, scr, rpc;
        logic        e_wr;
        logic [31:0] e_a, e_b;
        logic        e_full, e_so;
        logic [3:0]  e_fc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        checks = 0; errors = 0; wr_pulses = 0; n = 0;
        reset = 1'b1; wrreg_in = 1'b0; data_a_in = '0; data_b_in = '0;
        fifo_full_in = 1'b0; screen_in = 1'b0; reset_pulsecounter_in = 1'b0;

        //          rst  wr  a             b             full scr rpc  e_wr e_a           e_b           e_full e_so e_fc
        tbl[0] = '{1'b1, 0, 32'h0,        32'h0,        0,   0,  0,   0,   32'h0,        32'h0,        0,     0,   4'd0};
        tbl[1] = '{1'b0, 0, 32'h0,        32'h0,        0,   0,  0,   0,   32'h0,        32'h0,        0,     0,   4'd0};
        tbl[2] = '{1'b0, 1, 32'h0000_0012, 32'h00AB_CDEF, 0,  0,  0,   0,   32'h0000_0012, 32'h00AB_CDEF, 0,    0,   4'd0};
        tbl[3] = '{1'b0, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0,  0,  0,   1,   32'h0000_0012, 32'h00AB_CDEF, 0,    0,   4'd0};
        tbl[4] = '{1'b0, 1, 32'h1111_1111, 32'h2222_2222, 0,  0,  0,   0,   32'h0000_0012, 32'h00AB_CDEF, 0,    0,   4'd0};
        tbl[5] = '{1'b0, 0, 32'h0,        32'h0,        1,   1,  0,   0,   32'h0000_0012, 32'h00AB_CDEF, 1,    1,   4'd1};
        tbl[6] = '{1'b0, 0, 32'h0,        32'h0,        0,   0,  0,   0,   32'h0000_0012, 32'h00AB_CDEF, 0,    1,   4'd1};
        tbl[7] = '{1'b0, 1, 32'h0000_0077, 32'h0000_0088, 0,  0,  0,   0,   32'h0000_0077, 32'h0000_0088, 0,    1,   4'd1};
        tbl[8] = '{1'b0, 0, 32'h0,        32'h0,        0,   0,  1,   1,   32'h0000_0077, 32'h0000_0088, 0,    0,   4'd0};
        tbl[9] = '{1'b0, 0, 32'h0,        32'h0,        0,   1,  1,   0,   32'h0000_0077, 32'h0000_0088, 0,    1,   4'd1};

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rst, tbl[i].wr, tbl[i].a, tbl[i].b, tbl[i].full, tbl[i].scr, tbl[i].rpc);
            chk($sformatf("tbl%0d_wr_en", i),  32'(fifo_wr_en),  32'(tbl[i].e_wr));
            chk($sformatf("tbl%0d_data_a", i), fifo_data_a,      tbl[i].e_a);
            chk($sformatf("tbl%0d_data_b", i), fifo_data_b,      tbl[i].e_b);
            chk($sformatf("tbl%0d_wrfull", i), 32'(wrfull_out),  32'(tbl[i].e_full));
            chk($sformatf("tbl%0d_screen", i), 32'(screen_out),  32'(tbl[i].e_so));
            chk($sformatf("tbl%0d_frames", i), 32'(frame_count), 32'(tbl[i].e_fc));
        end

        // Long high level yields one write; a fresh rise yields another.
        do_reset(1'b0);
        drv(0, 0, 0, 0); drv(0, 0, 0, 0);
        wr_pulses = 0;
        for (int i = 0; i < 10; i++) drv(1, 0, 0, 0);
        chk("hold_one_write", 32'(wr_pulses), 32'd1);
        drv(0, 0, 0, 0); drv(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drv(1, 0, 0, 0);
        chk("second_write", 32'(wr_pulses), 32'd2);

        // Requests while full are dropped.
        do_reset(1'b0);
        drv(0, 1, 0, 0);
        chk("wrfull_delayed", 32'(wrfull_out), 32'd1);
        wr_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 0, 0);
            drv(0, 1, 0, 0);
        end
        chk("full_no_write", 32'(wr_pulses), 32'd0);
        chk("drop_three", 32'(drop_count), DROP_EN ? 32'd3 : 32'd0);

        // Frame counting, clear-then-set ordering, and a plain clear.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            drv(0, 0, 1, 0);
            drv(0, 0, 0, 0);
        end
        chk("frames_five", 32'(frame_count), 32'd5);
        chk("screen_set", 32'(screen_out), 32'd1);
        drv(0, 0, 1, 1);
        chk("clr_and_frame_cnt", 32'(frame_count), 32'd1);
        chk("clr_and_frame_so", 32'(screen_out), 32'd1);
        drv(0, 0, 0, 0);
        drv(0, 0, 0, 1);
        chk("clear_cnt", 32'(frame_count), 32'd0);
        chk("clear_so", 32'(screen_out), 32'd0);

        // Reset while entering WRITE kills the strobe; a held level is then ignored.
        do_reset(1'b0);
        drv(0, 0, 1, 0);
        step(1'b0, 1'b1, 32'h55, 32'h66, 1'b0, 1'b0, 1'b0);
        wr_pulses = 0;
        step(1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_in_write_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_in_write_a", fifo_data_a, 32'd0);
        chk("rst_in_write_fc", 32'(frame_count), 32'd0);
        for (int i = 0; i < 4; i++) drv(1, 0, 0, 0);
        chk("held_after_reset", 32'(wr_pulses), 32'd0);
        drv(0, 0, 0, 0);
        step(1'b0, 1'b1, 32'hA5A5_0001, 32'h5A5A_0002, 1'b0, 1'b0, 1'b0);
        drv(1, 0, 0, 0);
        chk("rerise_write", 32'(wr_pulses), 32'd1);
        chk("rerise_data", fifo_data_a, 32'hA5A5_0001);

        // Full rising during WRITE does not cancel the strobe.
        do_reset(1'b0);
        drv(0, 0, 0, 0);
        drv(1, 0, 0, 0);
        drv(1, 1, 0, 0);
        chk("full_in_write", 32'(fifo_wr_en), 32'd1);

        // Counter saturation with a 4-bit counter.
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            drv(1, 1, 1, 0);
            drv(0, 1, 1, 0);
        end
        chk("drop_sat", 32'(drop_count), DROP_EN ? 32'hF : 32'd0);
        chk("frame_sat", 32'(frame_count), 32'hF);

        // Randomized traffic against the model.
        begin
            logic w, p;
            w = 1'b0; p = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 2) == 0) w = ~w;
                if ($urandom_range(0, 5) == 0) p = ~p;
                step($urandom_range(0, 99) == 0, w, $urandom, $urandom,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, p);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
